wave_union_decoder: RTL and testbench

- Receiver-side decoder for the wave-union carry-chain launcher.
- Accepts one captured tapped-delay-line snapshot per hit and removes bubbles with a 3-tap majority filter.
- Finds every transition in the snapshot by scanning it in fixed-width chunks, then reports edge count, sum of edge positions and first-edge position over a valid/ready handshake.
- Sits between the TDL capture register and the fine-time averaging/calibration stage.

---
 rtl/wave_union_pkg.sv | 19 +
 rtl/wave_union_bubble_filter.sv | 21 ++
 rtl/wave_union_decoder.sv | 134 +++++++++++++
 tb/tb_wave_union_decoder.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/wave_union_pkg.sv
// Shared sizes and FSM encoding for the wave-union TDL decoder.
// Tap 0 sits nearest the carry-chain input.
package wave_union_pkg;
  localparam int TAPS = 56;
  localparam int CHUNK = 8;
  localparam int NCH = TAPS / CHUNK;
  localparam int MAX_EDGES = 8;
  localparam int POS_W = $clog2(TAPS);
  localparam int CNT_W = $clog2(TAPS + 1);
  localparam int SUM_W = POS_W + CNT_W;
  localparam int K_W = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    FILT,
    SCAN,
    DONE
  } state_t;
endpackage

// File: rtl/wave_union_bubble_filter.sv
// 3-tap majority bubble filter followed by transition detection.
// End taps replicate their neighbour so the boundaries see no fake edge.
module wave_union_bubble_filter
  import wave_union_pkg::*;
(
  input  logic [TAPS-1:0] raw,
  output logic [TAPS-1:0] edge_vec
);
  logic [TAPS+1:0] ext;
  logic [TAPS-1:0] filt;

  assign ext = {raw[TAPS-1], raw, raw[0]};

  for (genvar i = 0; i < TAPS; i++) begin : g_maj
    assign filt[i] = (ext[i] & ext[i+1])
                   | (ext[i] & ext[i+2])
                   | (ext[i+1] & ext[i+2]);
  end

  assign edge_vec = {filt[TAPS-1:1] ^ filt[TAPS-2:0], 1'b0};
endmodule

// File: rtl/wave_union_decoder.sv
// Wave-union TDL decoder: filters a snapshot, scans it chunk by chunk
// and reports edge count, position sum and first edge.
module wave_union_decoder
  import wave_union_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [TAPS-1:0]  tdl_bits,
  output logic             hit_dropped,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] edge_cnt,
  output logic [SUM_W-1:0] pos_sum,
  output logic [POS_W-1:0] first_pos,
  output logic             err
);
  state_t state_q, state_d;

  logic [TAPS-1:0]  raw_q;
  logic [TAPS-1:0]  e_q;
  logic [TAPS-1:0]  e_comb;
  logic [K_W-1:0]   k_q;
  logic [CNT_W-1:0] acc_cnt;
  logic [SUM_W-1:0] acc_sum;
  logic [POS_W-1:0] acc_first;
  logic             acc_found;

  logic [CNT_W-1:0] ch_cnt, nxt_cnt;
  logic [SUM_W-1:0] ch_sum, nxt_sum;
  logic [POS_W-1:0] ch_first, nxt_first;
  logic             ch_found, nxt_found;
  logic             last;

  wave_union_bubble_filter u_filt (
    .raw      (raw_q),
    .edge_vec (e_comb)
  );

  assign last = (k_q == K_W'(NCH - 1));

  // Descending scan leaves the lowest set index in ch_first.
  always_comb begin
    ch_cnt = '0;
    ch_sum = '0;
    ch_first = '0;
    ch_found = 1'b0;
    for (int i = TAPS - 1; i >= 0; i--) begin
      if (e_q[i] && ((i / CHUNK) == int'(k_q))) begin
        ch_cnt = ch_cnt + CNT_W'(1);
        ch_sum = ch_sum + SUM_W'(i);
        ch_first = POS_W'(i);
        ch_found = 1'b1;
      end
    end
  end

  assign nxt_cnt = acc_cnt + ch_cnt;
  assign nxt_sum = acc_sum + ch_sum;
  assign nxt_first = acc_found ? acc_first : ch_first;
  assign nxt_found = acc_found | ch_found;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    in_ready = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = FILT;
      end
      FILT: state_d = SCAN;
      SCAN: if (last) state_d = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign hit_dropped = in_valid && !in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw_q <= '0;
      e_q <= '0;
      k_q <= '0;
      acc_cnt <= '0;
      acc_sum <= '0;
      acc_first <= '0;
      acc_found <= 1'b0;
      edge_cnt <= '0;
      pos_sum <= '0;
      first_pos <= '0;
      err <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (in_valid) raw_q <= tdl_bits;
        FILT: begin
          e_q <= e_comb;
          k_q <= '0;
          acc_cnt <= '0;
          acc_sum <= '0;
          acc_first <= '0;
          acc_found <= 1'b0;
        end
        SCAN: begin
          acc_cnt <= nxt_cnt;
          acc_sum <= nxt_sum;
          acc_first <= nxt_first;
          acc_found <= nxt_found;
          k_q <= k_q + K_W'(1);
          if (last) begin
            edge_cnt <= nxt_cnt;
            pos_sum <= nxt_sum;
            first_pos <= nxt_first;
            err <= (nxt_cnt == '0) || (nxt_cnt > CNT_W'(MAX_EDGES));
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_wave_union_decoder.sv
// Directed bench for wave_union_decoder with a tap-level reference model.
// Results are checked against the model whenever out_valid is high.
module tb_wave_union_decoder;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [55:0] tdl_bits;
  logic        hit_dropped;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  edge_cnt;
  logic [11:0] pos_sum;
  logic [5:0]  first_pos;
  logic        err;

  wave_union_decoder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .tdl_bits    (tdl_bits),
    .hit_dropped (hit_dropped),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .edge_cnt    (edge_cnt),
    .pos_sum     (pos_sum),
    .first_pos   (first_pos),
    .err         (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cnt;
    int sum;
    int first;
    int err;
    int acc;
  } res_t;

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  bit   prev_ov = 1'b0;
  res_t exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic res_t model(input logic [55:0] raw);
    res_t r;
    int f[56];
    int l, c, rr;
    r = '{default: 0};
    for (int i = 0; i < 56; i++) begin
      l = int'(raw[(i == 0) ? 0 : i - 1]);
      c = int'(raw[i]);
      rr = int'(raw[(i == 55) ? 55 : i + 1]);
      f[i] = (l + c + rr >= 2) ? 1 : 0;
    end
    for (int i = 1; i < 56; i++) begin
      if (f[i] != f[i-1]) begin
        r.cnt++;
        r.sum += i;
        if (r.first == 0) r.first = i;
      end
    end
    r.err = (r.cnt == 0 || r.cnt > 8) ? 1 : 0;
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    res_t r;
    if (rst_n && in_valid && in_ready) begin
      r = model(tdl_bits);
      r.acc = cyc + 1;
      exp_q.push_back(r);
    end
    if (rst_n && out_valid && out_ready && exp_q.size() > 0)
      void'(exp_q.pop_front());
  end

  always @(negedge rst_n) exp_q.delete();

  always @(negedge clk) begin
    res_t e;
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        e = exp_q[0];
        chk("edge_cnt", int'(edge_cnt), e.cnt);
        chk("pos_sum", int'(pos_sum), e.sum);
        chk("first_pos", int'(first_pos), e.first);
        chk("err", int'(err), e.err);
        chk("in_ready_busy", int'(in_ready), 0);
        if (!prev_ov) chk("latency", cyc - e.acc, 8);
      end
    end
    prev_ov = rst_n && out_valid;
  end

  task automatic send(input logic [55:0] v);
    int n = 0;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("timeout_in_ready", 0, 1);
    end else begin
      tdl_bits = v;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_result();
    int n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) chk("timeout_out_valid", 0, 1);
    else if (out_ready) @(negedge clk);
  endtask

  logic [55:0] vec [8];
  int lit_cnt [8];
  int lit_sum [8];
  int lit_first [8];
  int lit_err [8];

  initial begin
    res_t m;
    vec[0] = 56'h0;             lit_cnt[0] = 0;  lit_sum[0] = 0;
    lit_first[0] = 0;  lit_err[0] = 1;
    vec[1] = 56'h3FF;           lit_cnt[1] = 1;  lit_sum[1] = 10;
    lit_first[1] = 10; lit_err[1] = 0;
    vec[2] = 56'hFF00FF;        lit_cnt[2] = 3;  lit_sum[2] = 48;
    lit_first[2] = 8;  lit_err[2] = 0;
    vec[3] = 56'h3DF;           lit_cnt[3] = 1;  lit_sum[3] = 10;
    lit_first[3] = 10; lit_err[3] = 0;
    vec[4] = 56'h4000_0000;     lit_cnt[4] = 0;  lit_sum[4] = 0;
    lit_first[4] = 0;  lit_err[4] = 1;
    vec[5] = 56'h3333_3333_3333_33; lit_cnt[5] = 27; lit_sum[5] = 756;
    lit_first[5] = 2;  lit_err[5] = 1;
    vec[6] = 56'hF0F0_F0F0;     lit_cnt[6] = 8;  lit_sum[6] = 144;
    lit_first[6] = 4;  lit_err[6] = 0;
    vec[7] = 56'hF000_00F0_F0F0_F0; lit_cnt[7] = 9; lit_sum[7] = 196;
    lit_first[7] = 4;  lit_err[7] = 1;

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    tdl_bits = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_hit_dropped", int'(hit_dropped), 0);
    chk("rst_edge_cnt", int'(edge_cnt), 0);
    chk("rst_pos_sum", int'(pos_sum), 0);
    chk("rst_first_pos", int'(first_pos), 0);
    chk("rst_err", int'(err), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int t = 0; t < 8; t++) begin
      m = model(vec[t]);
      chk("model_cnt", m.cnt, lit_cnt[t]);
      chk("model_sum", m.sum, lit_sum[t]);
      chk("model_first", m.first, lit_first[t]);
      chk("model_err", m.err, lit_err[t]);
      send(vec[t]);
      wait_result();
    end

    // Backpressure: hold result, offer two hits that must be dropped.
    out_ready = 1'b0;
    send(56'h3FF);
    wait_result();
    for (int c = 0; c < 5; c++) begin
      in_valid = (c == 1 || c == 3);
      tdl_bits = 56'hFFFF;
      #1;
      chk("bp_hit_dropped", int'(hit_dropped), int'(in_valid));
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_out_valid", int'(out_valid), 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("bp_no_capture", exp_q.size(), 1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", int'(out_valid), 0);
    chk("bp_release_ready", int'(in_ready), 1);
    send(56'hFF00FF);
    wait_result();

    // Reset in the middle of the scan.
    send(56'hFF00FF);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", int'(out_valid), 0);
    chk("abort_in_ready", int'(in_ready), 1);
    chk("abort_edge_cnt", int'(edge_cnt), 0);
    chk("abort_pos_sum", int'(pos_sum), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("abort_no_result", int'(out_valid), 0);
    out_ready = 1'b0;
    send(56'h3FF);
    wait_result();
    chk("post_rst_edge_cnt", int'(edge_cnt), 1);
    chk("post_rst_pos_sum", int'(pos_sum), 10);
    chk("post_rst_first", int'(first_pos), 10);
    out_ready = 1'b1;
    @(negedge clk);
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
